// File: rtl/fetch.sv
// Two-phase (toggle-handshake) instruction fetch stage bridging an upstream request, a memory port and a downstream consumer.
// Optional FETCH_SYNC_EN: adds a 2-flop synchronizer on triggerIn/readyIn, lengthening each event-to-action latency by one cycle.
module fetch (
    input  logic        clk,
    input  logic        reset,
    input  logic        triggerIn,
    input  logic [31:0] pcIn,
    output logic        triggerOut,
    output logic [31:0] addrOut,
    input  logic        readyIn,
    input  logic [31:0] dataIn,
    output logic [31:0] dataOut,
    output logic [31:0] pcOut,
    output logic        readyOut
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      state, state_nx;
    logic        trig_s, rdy_s;
    logic        trig_ref, rdy_ref;
    logic        trig_ev, rdy_ev;
    logic        pending, pending_nx;
    logic        trig_out_nx, ready_out_nx;
    logic [31:0] addr_nx, data_nx, pc_nx;

`ifdef FETCH_SYNC_EN
    logic trig_m, rdy_m;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trig_m <= 1'b0;
            rdy_m  <= 1'b0;
            trig_s <= 1'b0;
            rdy_s  <= 1'b0;
        end else begin
            trig_m <= triggerIn;
            rdy_m  <= readyIn;
            trig_s <= trig_m;
            rdy_s  <= rdy_m;
        end
    end
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trig_s <= 1'b0;
            rdy_s  <= 1'b0;
        end else begin
            trig_s <= triggerIn;
            rdy_s  <= readyIn;
        end
    end
`endif

    // Reference copies follow the sampled inputs every cycle, so each event lasts exactly one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trig_ref <= 1'b0;
            rdy_ref  <= 1'b0;
        end else begin
            trig_ref <= trig_s;
            rdy_ref  <= rdy_s;
        end
    end

    assign trig_ev = trig_s ^ trig_ref;
    assign rdy_ev  = rdy_s ^ rdy_ref;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx     = state;
        pending_nx   = pending;
        trig_out_nx  = triggerOut;
        ready_out_nx = readyOut;
        addr_nx      = addrOut;
        data_nx      = dataOut;
        pc_nx        = pcOut;
        unique case (state)
            IDLE: begin
                if (trig_ev) begin
                    addr_nx     = pcIn;
                    trig_out_nx = ~triggerOut;
                    state_nx    = WAIT;
                end
            end
            REQ: begin
                // Launch the queued fetch; a fresh trigger arriving now becomes the new pending one.
                addr_nx     = pcIn;
                trig_out_nx = ~triggerOut;
                pending_nx  = trig_ev;
                state_nx    = WAIT;
            end
            WAIT: begin
                if (trig_ev) pending_nx = 1'b1;
                if (rdy_ev) begin
                    data_nx  = dataIn;
                    pc_nx    = addrOut + 32'd4;
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (trig_ev) pending_nx = 1'b1;
                ready_out_nx = ~readyOut;
                state_nx     = pending_nx ? REQ : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending    <= 1'b0;
            triggerOut <= 1'b0;
            readyOut   <= 1'b0;
            addrOut    <= 32'd0;
            dataOut    <= 32'd0;
            pcOut      <= 32'd0;
        end else begin
            pending    <= pending_nx;
            triggerOut <= trig_out_nx;
            readyOut   <= ready_out_nx;
            addrOut    <= addr_nx;
            dataOut    <= data_nx;
            pcOut      <= pc_nx;
        end
    end

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for fetch: table-driven fetch vectors with a scoreboard, plus pending, idle-ready and mid-fetch reset sequences.
module tb_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        triggerIn;
    logic [31:0] pcIn;
    logic        triggerOut;
    logic [31:0] addrOut;
    logic        readyIn;
    logic [31:0] dataIn;
    logic [31:0] dataOut;
    logic [31:0] pcOut;
    logic        readyOut;

`ifdef FETCH_SYNC_EN
    localparam int LAT_ISSUE = 3;
    localparam int LAT_DATA  = 3;
`else
    localparam int LAT_ISSUE = 2;
    localparam int LAT_DATA  = 2;
`endif
    localparam int LAT_READY = LAT_DATA + 1;
    localparam int BOUND     = 20;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        logic [31:0] exp_pc;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] pcout;
    } sb_t;

    vec_t vecs[4];
    sb_t  sb[$];
    int   tests = 0;
    int   failed = 0;
    int   t_tog = 0;
    logic last_t = 1'b0;

    fetch dut (
        .clk       (clk),
        .reset     (reset),
        .triggerIn (triggerIn),
        .pcIn      (pcIn),
        .triggerOut(triggerOut),
        .addrOut   (addrOut),
        .readyIn   (readyIn),
        .dataIn    (dataIn),
        .dataOut   (dataOut),
        .pcOut     (pcOut),
        .readyOut  (readyOut)
    );

    always #5 clk = ~clk;

    // Counts triggerOut toggles, sampled away from the active edge.
    always @(negedge clk) begin
        if (triggerOut !== last_t) t_tog++;
        last_t = triggerOut;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive_trig(input logic [31:0] pc, input logic [31:0] data, input logic [31:0] pcout);
        sb_t e;
        @(negedge clk);
        pcIn      = pc;
        triggerIn = ~triggerIn;
        e.addr  = pc;
        e.data  = data;
        e.pcout = pcout;
        sb.push_back(e);
    endtask

    task automatic wait_issue(input bit chk_lat);
        logic old;
        int   cyc;
        bit   seen;
        old  = triggerOut;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < BOUND) begin
            @(posedge clk);
            #1;
            cyc++;
            if (triggerOut !== old) seen = 1'b1;
        end
        if (!seen) cyc = 99;
        if (chk_lat || !seen) check("issue latency", 32'(cyc), 32'(LAT_ISSUE));
        if (sb.size() > 0) check("addrOut", addrOut, sb[0].addr);
    endtask

    task automatic complete(input bit chk_lat);
        logic        old_r;
        logic [31:0] old_d;
        int          cyc, d_cyc;
        bit          seen;
        sb_t         e;
        @(negedge clk);
        dataIn  = (sb.size() > 0) ? sb[0].data : 32'd0;
        readyIn = ~readyIn;
        old_r = readyOut;
        old_d = dataOut;
        cyc   = 0;
        d_cyc = 99;
        seen  = 1'b0;
        while (!seen && cyc < BOUND) begin
            @(posedge clk);
            #1;
            cyc++;
            if (d_cyc == 99 && dataOut !== old_d) d_cyc = cyc;
            if (readyOut !== old_r) seen = 1'b1;
        end
        if (!seen) cyc = 99;
        if (chk_lat || !seen) begin
            check("data latency", 32'(d_cyc), 32'(LAT_DATA));
            check("readyOut latency", 32'(cyc), 32'(LAT_READY));
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("dataOut", dataOut, e.data);
            check("pcOut", pcOut, e.pcout);
        end
    endtask

    initial begin
        logic [31:0] s_data, s_pc, s_addr;
        logic        s_rdy, s_trig;
        int          t0;

        vecs[0] = '{pc: 32'h0000_0000, data: 32'h0000_00FF, exp_pc: 32'h0000_0004};
        vecs[1] = '{pc: 32'hFFFF_FFFC, data: 32'hDEAD_BEEF, exp_pc: 32'h0000_0000};
        vecs[2] = '{pc: 32'h0000_1000, data: 32'h0000_0013, exp_pc: 32'h0000_1004};
        vecs[3] = '{pc: 32'h7FFF_FFFC, data: 32'hA5A5_A5A5, exp_pc: 32'h8000_0000};

        reset     = 1'b1;
        triggerIn = 1'b0;
        readyIn   = 1'b0;
        pcIn      = 32'd0;
        dataIn    = 32'd0;
        repeat (3) @(negedge clk);
        check("reset triggerOut", 32'(triggerOut), 32'd0);
        check("reset readyOut", 32'(readyOut), 32'd0);
        check("reset addrOut", addrOut, 32'd0);
        check("reset dataOut", dataOut, 32'd0);
        check("reset pcOut", pcOut, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Basic fetches, including address wrap-around.
        for (int i = 0; i < 4; i++) begin
            drive_trig(vecs[i].pc, vecs[i].data, vecs[i].exp_pc);
            wait_issue(1'b1);
            complete(1'b1);
            repeat (2) @(negedge clk);
        end

        // Two triggers during WAIT: one becomes pending, the second is dropped.
        t0 = t_tog;
        drive_trig(32'h0000_0100, 32'h0000_0011, 32'h0000_0104);
        wait_issue(1'b1);
        drive_trig(32'h0000_0200, 32'h0000_0022, 32'h0000_0204);
        repeat (3) @(negedge clk);
        pcIn      = 32'h0000_0300;
        triggerIn = ~triggerIn;
        @(negedge clk);
        pcIn = 32'h0000_0200;
        repeat (3) @(negedge clk);
        complete(1'b1);
        wait_issue(1'b0);
        complete(1'b1);
        repeat (10) @(negedge clk);
        check("triggerOut toggles", 32'(t_tog - t0), 32'd2);

        // readyIn toggle while idle must not disturb anything.
        s_data = dataOut;
        s_pc   = pcOut;
        s_addr = addrOut;
        s_rdy  = readyOut;
        s_trig = triggerOut;
        @(negedge clk);
        readyIn = ~readyIn;
        repeat (6) @(negedge clk);
        check("idle ready dataOut", dataOut, s_data);
        check("idle ready pcOut", pcOut, s_pc);
        check("idle ready addrOut", addrOut, s_addr);
        check("idle ready readyOut", 32'(readyOut), 32'(s_rdy));
        check("idle ready triggerOut", 32'(triggerOut), 32'(s_trig));

        // Reset during WAIT aborts the fetch.
        drive_trig(32'h0000_0400, 32'h0000_0055, 32'h0000_0404);
        wait_issue(1'b1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midreset triggerOut", 32'(triggerOut), 32'd0);
        check("midreset readyOut", 32'(readyOut), 32'd0);
        check("midreset addrOut", addrOut, 32'd0);
        check("midreset dataOut", dataOut, 32'd0);
        check("midreset pcOut", pcOut, 32'd0);
        sb.delete();
        triggerIn = 1'b0;
        readyIn   = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        check("post reset readyOut", 32'(readyOut), 32'd0);
        check("post reset triggerOut", 32'(triggerOut), 32'd0);

        // Recovery after reset.
        drive_trig(32'h0000_0040, 32'h0000_0077, 32'h0000_0044);
        wait_issue(1'b1);
        complete(1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
